// File: rtl/i3c_table_mem_ctrl.sv
// I3C DAT/DCT table memory controller: N-port round-robin front-end
// with masked writes, range checks, pipelined reads and zeroization.
module i3c_table_mem_ctrl #(
  parameter int NumPorts        = 2,
  parameter int Depth           = 128,
  parameter int Width           = 64,
  parameter int DataBitsPerMask = 32,
  parameter int ReadLatency     = 1,
  localparam int AddrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int NumLanes  = Width / DataBitsPerMask
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  output logic                          init_done_o,
  input  logic [NumPorts-1:0]           req_i,
  input  logic [NumPorts-1:0]           write_i,
  input  logic [NumPorts*AddrWidth-1:0] addr_i,
  input  logic [NumPorts*Width-1:0]     wdata_i,
  input  logic [NumPorts*NumLanes-1:0]  wmask_i,
  output logic [NumPorts-1:0]           gnt_o,
  output logic [NumPorts-1:0]           rvalid_o,
  output logic [NumPorts*Width-1:0]     rdata_o,
  output logic [NumPorts-1:0]           rerror_o
);

  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam logic [AddrWidth:0] DepthW = (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(Depth - 1);
  localparam int Dbm = DataBitsPerMask;

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;

  logic                 serve;
  logic                 any_gnt;
  logic [PtrW-1:0]      win;
  logic [AddrWidth-1:0] sel_addr;
  logic                 sel_write;
  logic [Width-1:0]     sel_wdata;
  logic [NumLanes-1:0]  sel_wmask;
  logic                 in_range;
  logic [Width-1:0]     rd_word;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AddrWidth'(1);
        end
      end
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (clear_i) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  assign init_done_o = (state_q == IDLE);
  assign serve = (state_q == IDLE) && !clear_i;

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    win     = '0;
    any_gnt = 1'b0;
    for (int k = NumPorts - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % NumPorts]) begin
        win     = PtrW'((int'(ptr_q) + k) % NumPorts);
        any_gnt = serve;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_gnt) gnt_o[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      if (int'(win) == NumPorts - 1) ptr_d = '0;
      else ptr_d = win + PtrW'(1);
    end
  end

  assign sel_addr  = addr_i[win*AddrWidth +: AddrWidth];
  assign sel_write = write_i[win];
  assign sel_wdata = wdata_i[win*Width +: Width];
  assign sel_wmask = wmask_i[win*NumLanes +: NumLanes];
  assign in_range  = {1'b0, sel_addr} < DepthW;
  assign rd_word   = in_range ? mem[sel_addr] : '0;

  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (any_gnt && sel_write && in_range) begin
      for (int l = 0; l < NumLanes; l++) begin
        if (sel_wmask[l])
          mem[sel_addr][l*Dbm +: Dbm] <= sel_wdata[l*Dbm +: Dbm];
      end
    end
  end

  logic            f_vld;
  logic            f_wr;
  logic            f_err;
  logic [PtrW-1:0] f_port;
  logic [Width-1:0] f_data;

  // Data is captured at the grant edge, so a clear never alters it.
  if (ReadLatency >= 2) begin : g_lat2
    logic             s1_vld;
    logic             s1_wr;
    logic             s1_err;
    logic [PtrW-1:0]  s1_port;
    logic [Width-1:0] s1_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_vld  <= 1'b0;
        s1_wr   <= 1'b0;
        s1_err  <= 1'b0;
        s1_port <= '0;
        s1_data <= '0;
      end else begin
        s1_vld  <= any_gnt;
        s1_wr   <= sel_write;
        s1_err  <= !in_range;
        s1_port <= win;
        s1_data <= rd_word;
      end
    end

    assign f_vld  = s1_vld;
    assign f_wr   = s1_wr;
    assign f_err  = s1_err;
    assign f_port = s1_port;
    assign f_data = s1_data;
  end else begin : g_lat1
    assign f_vld  = any_gnt;
    assign f_wr   = sel_write;
    assign f_err  = !in_range;
    assign f_port = win;
    assign f_data = rd_word;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= '0;
      rerror_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      rerror_o <= '0;
      if (f_vld) begin
        rvalid_o[f_port] <= !f_wr;
        rerror_o[f_port] <= f_err;
        if (!f_wr) rdata_o[f_port*Width +: Width] <= f_data;
      end
    end
  end

endmodule

// File: tb/tb_i3c_table_mem_ctrl.sv
// Scoreboard bench for i3c_table_mem_ctrl: random and directed traffic
// checked against an array model with a cyclic-priority arbiter.
module tb_i3c_table_mem_ctrl;

  localparam int NP    = 3;
  localparam int DEPTH = 100;
  localparam int W     = 64;
  localparam int DB    = 32;
  localparam int RL    = 2;
  localparam int AW    = 7;
  localparam int NL    = W / DB;

  logic clk = 0;
  logic rst_n = 0;
  logic clear = 0;
  logic init_done;
  logic [NP-1:0] req = '0;
  logic [NP-1:0] wr = '0;
  logic [NP-1:0] gnt, rvalid, rerror;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*W-1:0] wdata = '0;
  logic [NP*W-1:0] rdata;
  logic [NP*NL-1:0] wmask = '0;

  i3c_table_mem_ctrl #(
    .NumPorts(NP), .Depth(DEPTH), .Width(W),
    .DataBitsPerMask(DB), .ReadLatency(RL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .init_done_o(init_done), .req_i(req), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .rerror_o(rerror)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [W-1:0] data;
    logic       err;
  } exp_t;

  exp_t q[NP][$];
  logic [W-1:0] model [DEPTH];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_win = NP - 1;
  int busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rvalid[p] || rerror[p]) begin
        if (q[p].size() == 0) begin
          chk("unexpected_resp", W'({rvalid[p], rerror[p]}), '0);
        end else begin
          exp_t e;
          e = q[p].pop_front();
          chk("resp_cycle", W'(cyc), W'(e.cyc));
          chk("rvalid", W'(rvalid[p]), W'(e.rd));
          if (e.rd) chk("rdata", rdata[p*W +: W], e.data);
          chk("rerror", W'(rerror[p]), W'(e.err));
        end
      end
    end
  end

  task automatic step();
    int win;
    logic [NP-1:0] expg;
    logic [AW-1:0] a;
    exp_t e;
    @(negedge clk);
    win = -1;
    expg = '0;
    if (clear) begin
      chk("init_done_clr", W'(init_done), W'(busy == 0));
      chk("gnt_clr", W'(gnt), '0);
    end else if (busy > 0) begin
      chk("init_done_busy", W'(init_done), '0);
      chk("gnt_busy", W'(gnt), '0);
      busy--;
    end else begin
      chk("init_done", W'(init_done), W'(1));
      for (int k = 1; k <= NP; k++)
        if (win < 0 && req[(last_win + k) % NP])
          win = (last_win + k) % NP;
      if (win >= 0) expg[win] = 1'b1;
      chk("gnt", W'(gnt), W'(expg));
    end
    if (win >= 0) begin
      last_win = win;
      a = addr[win*AW +: AW];
      e.cyc = cyc + RL;
      e.err = (a >= DEPTH);
      if (wr[win]) begin
        e.rd = 1'b0;
        e.data = '0;
        if (a < DEPTH) begin
          for (int l = 0; l < NL; l++)
            if (wmask[win*NL + l])
              model[a][l*DB +: DB] = wdata[win*W + l*DB +: DB];
        end else begin
          q[win].push_back(e);
        end
      end else begin
        e.rd = 1'b1;
        e.data = (a < DEPTH) ? model[a] : '0;
        q[win].push_back(e);
      end
    end
    if (clear) begin
      foreach (model[i]) model[i] = '0;
      busy = DEPTH;
    end
    @(posedge clk);
    #1;
    clear = 0;
    if (win >= 0) req[win] = 1'b0;
  endtask

  task automatic issue(int p, bit w, int a, logic [W-1:0] d,
                       logic [NL-1:0] m);
    if (!req[p]) begin
      req[p] = 1'b1;
      wr[p] = w;
      addr[p*AW +: AW] = AW'(a);
      wdata[p*W +: W] = d;
      wmask[p*NL +: NL] = m;
    end
  endtask

  task automatic issue_rand(int p);
    issue(p, bit'($urandom_range(0, 1)), $urandom_range(0, 127),
          {$urandom, $urandom}, NL'($urandom_range(0, 3)));
  endtask

  function automatic bit queues_empty();
    for (int p = 0; p < NP; p++)
      if (q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while ((req != '0 || !queues_empty()) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", W'(n < 300), W'(1));
  endtask

  task automatic do_reset();
    int n = 0;
    rst_n = 0;
    req = '0;
    clear = 0;
    for (int p = 0; p < NP; p++) q[p].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", W'(init_done), '0);
    chk("rst_gnt", W'(gnt), '0);
    chk("rst_rvalid", W'(rvalid), '0);
    chk("rst_rerror", W'(rerror), '0);
    chk("rst_rdata", rdata[W-1:0] | rdata[W +: W] | rdata[2*W +: W], '0);
    @(posedge clk);
    #1 rst_n = 1;
    while (n < 3 * DEPTH) begin
      @(posedge clk);
      n++;
      #1;
      if (init_done) break;
    end
    chk("init_cycles_ok", W'(n == DEPTH || n == DEPTH + 1), W'(1));
    foreach (model[i]) model[i] = '0;
    last_win = NP - 1;
    busy = 0;
  endtask

  initial begin
    do_reset();

    for (int a = 0; a < DEPTH; a++) begin
      issue(0, 0, a, '0, '0);
      drain();
    end

    for (int c = 0; c < 9; c++) begin
      for (int p = 0; p < NP; p++)
        issue(p, 0, $urandom_range(0, DEPTH - 1), '0, '0);
      step();
    end
    drain();

    issue(1, 1, 10, '1, 2'b11);
    drain();
    issue(1, 1, 10, 64'h1234_5678_9ABC_DEF0, 2'b01);
    drain();
    issue(1, 0, 10, '0, '0);
    drain();
    issue(2, 1, 10, '0, 2'b00);
    drain();
    issue(2, 0, 10, '0, '0);
    drain();

    issue(0, 1, 5, 64'h5555_0000_AAAA_0005, 2'b11);
    drain();
    issue(0, 1, 6, 64'h6666_1111_BBBB_0006, 2'b11);
    drain();
    issue(2, 0, 5, '0, '0);
    step();
    issue(2, 0, 6, '0, '0);
    step();
    drain();

    issue(0, 1, 20, 64'hDEAD_BEEF_0BAD_F00D, 2'b11);
    step();
    issue(1, 0, 20, '0, '0);
    drain();

    issue(0, 0, 100, '0, '0);
    drain();
    issue(1, 1, 127, '1, 2'b11);
    drain();
    for (int a = 0; a < DEPTH; a++) begin
      issue(a % NP, 0, a, '0, '0);
      drain();
    end

    issue(0, 1, 3, 64'hA5, 2'b11);
    drain();
    issue(0, 0, 3, '0, '0);
    step();
    clear = 1;
    step();
    for (int c = 0; c < DEPTH; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 3) == 0) issue_rand(p);
      step();
    end
    drain();
    issue(0, 0, 3, '0, '0);
    drain();

    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) == 0) issue_rand(p);
      clear = ($urandom_range(0, 299) == 0);
      step();
    end
    drain();

    issue(1, 0, 7, '0, '0);
    step();
    do_reset();
    repeat (4) step();
    issue(2, 0, 7, '0, '0);
    drain();

    chk("queues_empty", W'(queues_empty()), W'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
